// File: rtl/icache_assoc.sv
// icache_assoc -- set-associative, read-only instruction cache.
//
// Lookup is zero latency: a hit in IDLE drives ihit/imemload in the same cycle.
// A miss latches the block base address. FILL then fetches BLOCK_WORDS words
// from memory, one word per cycle where iwait is low. The block is written
// into the victim way when the last word arrives. flush invalidates every
// entry and also aborts a fill that is in progress.
//
// Parameters: SETS (power of two, 2..64), WAYS (1 or 2), BLOCK_WORDS (1, 2 or 4).
// Ports:
//   clk, nRST            clock, asynchronous active-low reset
//   imemREN, imemaddr    datapath fetch request and byte address
//   flush                invalidate all entries
//   ihit, imemload       hit strobe and instruction word (zero when no hit)
//   iREN, iaddr          memory read request and word address (FILL only)
//   iwait, iload         memory busy and read data
//   hit_count,           statistics counters; they exist only when
//   miss_count           ICACHE_STATS_EN is defined and read 0 otherwise

module icache_assoc_way #(
  parameter int TAG_W = 26
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag_q,
  input  logic [TAG_W-1:0] tag_req,
  output logic             match
);
  assign match = vld && (tag_q == tag_req);
endmodule

module icache_assoc #(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      base_q;

  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]           lru_q;
  logic [TAG_W-1:0]          tag_arr  [WAYS][SETS];
  logic [31:0]               data_arr [WAYS][SETS][BLOCK_WORDS];
  logic [31:0]               fbuf     [BLOCK_WORDS];

  // Request address split
  logic [CNT_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign off = (BLOCK_WORDS == 1) ? '0 : CNT_W'(imemaddr >> 2);
  assign idx = IDX_W'(imemaddr >> (2 + OFF_W));
  assign tag = TAG_W'(imemaddr >> (2 + OFF_W + IDX_W));

  // Fill address split (from the latched base)
  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  assign fidx = IDX_W'(base_q >> (2 + OFF_W));
  assign ftag = TAG_W'(base_q >> (2 + OFF_W + IDX_W));

  // Tag compare, one instance per way
  logic [WAYS-1:0] match;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_assoc_way #(.TAG_W(TAG_W)) u_way (
      .vld     (valid_q[w][idx]),
      .tag_q   (tag_arr[w][idx]),
      .tag_req (tag),
      .match   (match[w])
    );
  end

  logic hit;
  logic hit_way, vic;
  assign hit = (state_q == IDLE) && imemREN && !flush && (|match);

  always_comb begin
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (match[w]) hit_way = 1'(w);
  end

  // Victim: lowest-index invalid way, otherwise the LRU way
  always_comb begin
    vic = (WAYS == 2) ? lru_q[fidx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w][fidx]) vic = 1'(w);
  end

  assign imemload = hit ? data_arr[hit_way][idx][off] : '0;
  assign iaddr    = (state_q == FILL) ? base_q + (32'(cnt_q) << 2) : '0;

  logic start, acc, done;

  always_comb begin
    state_d = state_q;
    ihit    = 1'b0;
    iREN    = 1'b0;
    start   = 1'b0;
    acc     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ihit = hit;
        if (imemREN && !flush && !(|match)) begin
          start   = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        iREN = 1'b1;
        if (flush) state_d = IDLE;
        else if (!iwait) begin
          acc = 1'b1;
          if (cnt_q == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        base_q <= (imemaddr >> (2 + OFF_W)) << (2 + OFF_W);
        cnt_q  <= '0;
      end
      if (acc) cnt_q <= done ? '0 : cnt_q + 1'b1;
      if (flush) begin
        valid_q <= '0;
        lru_q   <= '0;
      end else begin
        // LRU points at the way that was not just used
        if (hit && WAYS == 2) lru_q[idx] <= ~hit_way;
        if (done) begin
          valid_q[vic][fidx] <= 1'b1;
          if (WAYS == 2) lru_q[fidx] <= ~vic;
        end
      end
    end
  end

  // Data/tag storage carries no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (acc) fbuf[cnt_q] <= iload;
    if (done) begin
      tag_arr[vic][fidx] <= ftag;
      // The last word comes straight from iload
      for (int w = 0; w < BLOCK_WORDS; w++)
        data_arr[vic][fidx][w] <= (CNT_W'(w) == cnt_q) ? iload : fbuf[w];
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Testbench for icache_assoc (default parameters: index [5:3], offset [2]).
// The memory model holds iwait high for 2 cycles per word. A scoreboard
// monitor compares each memory word accepted and each hit against the
// queued expectations.

module tb_icache_assoc;
  logic        clk = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count, miss_count;

  int nchk = 0;
  int nfail = 0;

  logic [31:0] exp_mem [$];
  logic [63:0] exp_hit [$];

  icache_assoc dut (
    .clk        (clk),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .flush      (flush),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h11110001;
      32'h44:  return 32'h22220002;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Memory: each word is accepted on the third cycle of its request
  logic [1:0] wcnt;
  always @(posedge clk or negedge nRST) begin
    if (!nRST) wcnt <= 2'd0;
    else if (!iREN || !iwait) wcnt <= 2'd0;
    else wcnt <= wcnt + 2'd1;
  end
  assign iwait = (wcnt != 2'd2);
  assign iload = memword(iaddr);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic fail_now(input string n, input logic [31:0] act);
    nchk++;
    nfail++;
    $display("FAIL %s: got %h with nothing expected", n, act);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    logic [63:0] h;
    if (iREN && !iwait) begin
      if (exp_mem.size() == 0) fail_now("mem_unexpected", iaddr);
      else begin
        e = exp_mem.pop_front();
        chk("mem_iaddr", iaddr, e);
      end
    end
    if (ihit) begin
      if (exp_hit.size() == 0) fail_now("hit_unexpected", imemaddr);
      else begin
        h = exp_hit.pop_front();
        chk("hit_addr", imemaddr, h[63:32]);
        chk("hit_data", imemload, h[31:0]);
      end
      if (iREN) fail_now("hit_with_iREN", iaddr);
    end
  end

  // One request held until it hits; miss=1 expects a two-word block fill first
  task automatic access(input logic [31:0] a, input bit miss);
    logic [31:0] b;
    bit got;
    b = {a[31:3], 3'b000};
    if (miss) begin
      exp_mem.push_back(b);
      exp_mem.push_back(b + 32'd4);
    end
    exp_hit.push_back({a, memword(a)});
    imemaddr = a;
    imemREN  = 1'b1;
    @(negedge clk);
    chk("first_cycle_ihit", {31'd0, ihit}, {31'd0, !miss});
    if (!miss) chk("hit_iREN", {31'd0, iREN}, 32'd0);
    got = ihit;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = ihit;
    end
    if (!got) fail_now("hit_timeout", a);
    @(posedge clk);
    #1 imemREN = 1'b0;
  endtask

  task automatic flush_pulse();
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_ihit", {31'd0, ihit}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic wait_iaddr(input logic [31:0] a);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1 seen = (iREN && iaddr == a);
    end
    if (!seen) fail_now("wait_iaddr_timeout", iaddr);
  endtask

  initial begin
    bit got;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
    #1;
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_iREN", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) nRST = 1'b1;

    // Cold miss of 0x40, then zero-latency hit on 0x44
    access(32'h40, 1);
    access(32'h44, 0);
`ifdef ICACHE_STATS_EN
    chk("stats_hits", hit_count, 32'd2);
    chk("stats_misses", miss_count, 32'd1);
`else
    chk("stats_hits", hit_count, 32'd0);
    chk("stats_misses", miss_count, 32'd0);
`endif

    // LRU replacement in set 0
    access(32'h80, 1);
    access(32'h40, 0);
    access(32'hC0, 1);
    access(32'h40, 0);
    access(32'h80, 1);

    // Flush during the second word of a fill of 0x40
    flush_pulse();
    exp_mem.push_back(32'h40);
    imemaddr = 32'h40; imemREN = 1'b1;
    wait_iaddr(32'h44);
    flush = 1'b1; imemREN = 1'b0;
    @(negedge clk);
    chk("flush_fill_ihit", {31'd0, ihit}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_abort_iREN", {31'd0, iREN}, 32'd0);
    @(posedge clk);
    #1 chk("flush_idle_iREN", {31'd0, iREN}, 32'd0);
    access(32'h40, 1);

    // Reset in the middle of a fill of 0x200
    imemaddr = 32'h200; imemREN = 1'b1;
    @(posedge clk);
    #1 chk("fill_iREN", {31'd0, iREN}, 32'd1);
    chk("fill_iaddr", iaddr, 32'h200);
    @(posedge clk);
    #1 nRST = 1'b0; imemREN = 1'b0;
    #1;
    chk("midrst_iREN", {31'd0, iREN}, 32'd0);
    chk("midrst_ihit", {31'd0, ihit}, 32'd0);
    chk("midrst_iaddr", iaddr, 32'd0);
    chk("midrst_hit_count", hit_count, 32'd0);
    chk("midrst_miss_count", miss_count, 32'd0);
    @(negedge clk) nRST = 1'b1;
    access(32'h40, 1);

    // Address change during a fill is ignored; the new address then misses
    flush_pulse();
    exp_mem.push_back(32'h40);
    exp_mem.push_back(32'h44);
    exp_mem.push_back(32'h100);
    exp_mem.push_back(32'h104);
    exp_hit.push_back({32'h100, memword(32'h100)});
    imemaddr = 32'h40; imemREN = 1'b1;
    wait_iaddr(32'h44);
    imemaddr = 32'h100;
    #1 chk("fill_latched_iaddr", iaddr, 32'h44);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = ihit;
    end
    if (!got) fail_now("hit_timeout_100", imemaddr);
    @(posedge clk);
    #1 imemREN = 1'b0;
    access(32'h40, 0);

    repeat (3) @(posedge clk);
    chk("mem_queue_left", exp_mem.size(), 32'd0);
    chk("hit_queue_left", exp_hit.size(), 32'd0);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks", nchk);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter SETS, default 8, number of sets; power of two, 2..64.
REQ-002 Parameter WAYS, default 2, associativity; 1 or 2.
REQ-003 Parameter BLOCK_WORDS, default 2, 32-bit words per block; 1, 2 or 4.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 nRST  input  1  asynchronous, active-low reset.
REQ-006 imemREN  input  1  datapath instruction read request.
REQ-007 imemaddr  input  32  datapath byte address; bits [1:0] ignored.
REQ-008 flush  input  1  invalidate all entries.
REQ-009 ihit  output  1  imemload valid for current imemaddr this cycle.
REQ-010 imemload  output  32  instruction word returned to datapath.
REQ-011 iREN  output  1  memory read request.
REQ-012 iaddr  output  32  memory word address, bits [1:0] = 0.
REQ-013 iwait  input  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0.
REQ-014 iload  input  32  memory read data.
REQ-015 hit_count  output  32  number of hit cycles.
REQ-016 miss_count  output  32  number of misses.

Function
REQ-017 Address split: [1:0] byte, next log2(BLOCK_WORDS) bits word offset, next log2(SETS) bits index, remaining upper bits tag.
REQ-018 Per way per set: valid bit, tag, BLOCK_WORDS data words; per set one LRU bit (WAYS=2 only).
REQ-019 FSM states IDLE and FILL; FILL holds a word counter 0..BLOCK_WORDS-1.
REQ-020 IDLE: hit when imemREN=1 and any valid way in the indexed set matches the tag; ihit=1 and imemload=selected word combinationally, same cycle (zero latency).
REQ-021 On hit with WAYS=2, the set's LRU bit is updated at the clock edge to point to the way not hit.
REQ-022 IDLE miss (imemREN=1, no match, flush=0): latch block base address, counter=0, go to FILL next cycle; ihit=0.
REQ-023 FILL: iREN=1, iaddr=base+4*counter; on iwait=0 store iload into fill buffer, increment counter.
REQ-024 Last word accepted: write block into victim way (invalid way first, lowest index; else LRU way), set valid, write tag, LRU points to other way, return to IDLE; request hits in the following cycle.
REQ-025 ihit=0 and iREN=1 for every FILL cycle; iREN=0 in IDLE.
REQ-026 imemaddr or imemREN changes during FILL are ignored; the latched block completes.
REQ-027 flush=1 clears all valid bits and LRU bits at the next edge; flush in FILL aborts the fill without writing, returns to IDLE; ihit=0 in any flush cycle.
REQ-028 imemREN=0 in IDLE: ihit=0, no state change.

Reset
REQ-029 nRST low: state IDLE, counter 0, all valid and LRU bits 0, counters 0; outputs ihit=0, iREN=0, iaddr=0, imemload=0, immediately and independent of clk, including mid-FILL.
REQ-030 Data and tag arrays need not be reset.

Configuration
REQ-031 Macro ICACHE_STATS_EN defined: hit_count increments each ihit=1 cycle, miss_count increments on each IDLE-to-FILL transition, both wrap at 2^32.
REQ-032 Macro undefined: no counter logic; hit_count and miss_count tied to 0.

Verification (defaults: index [5:3], offset [2])
REQ-033 Cold miss 0x40, memory 0x40=0x11110001, 0x44=0x22220002, iwait high 2 cycles per word -> iREN with iaddr 0x40 then 0x44, then ihit=1, imemload=0x11110001; next request 0x44 hits same cycle, iREN=0.
REQ-034 Fill 0x40, fill 0x80, hit 0x40, request 0xC0 -> 0x80 evicted; then 0x40 hits, 0x80 misses.
REQ-035 flush=1 during second word of a fill of 0x40 -> iREN=0 next cycle, state IDLE; re-request 0x40 misses and refetches from 0x40.
REQ-036 nRST=0 mid-FILL -> iREN=0, ihit=0 immediately; after release previously filled 0x40 misses.
REQ-037 imemaddr changes 0x40 to 0x100 during fill of 0x40 -> iaddr stays 0x40/0x44, fill completes, then 0x100 misses.
REQ-038 With ICACHE_STATS_EN, sequence of REQ-033 -> hit_count=2, miss_count=1; without the macro both read 0.
